// File: rtl/sample_packer.sv
// Packs SAMPLE_LEN-bit probe samples LSB-first into DATA_LEN-bit words for the capture FIFO.
// Optional build macro PACKER_CHANGE_ONLY_EN: accept a sample only when it differs from the last accepted one.
module sample_packer #(
    parameter int DATA_LEN   = 32,
    parameter int SAMPLE_LEN = 8
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  sample_valid_i,
    input  logic [SAMPLE_LEN-1:0] sample_i,
    input  logic                  full_i,
    output logic [DATA_LEN-1:0]   data_o,
    output logic                  wen_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int SPW    = DATA_LEN / SAMPLE_LEN;
    localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [SLOT_W-1:0]     slot_reg;
    logic [DATA_LEN-1:0]   acc_reg;
    logic [DATA_LEN-1:0]   out_reg;
    logic                  pending_reg;
    logic                  overflow_reg;

    logic [DATA_LEN-1:0]   word_ins;
    logic                  changed;
    logic                  free;
    logic                  start;
    logic                  accept;
    logic                  complete;
    logic                  flush_load;

    // Accumulator with the incoming sample dropped into the current slot.
    genvar gi;
    generate
        for (gi = 0; gi < SPW; gi++) begin : g_slot
            assign word_ins[gi*SAMPLE_LEN +: SAMPLE_LEN] =
                (slot_reg == SLOT_W'(gi)) ? sample_i : acc_reg[gi*SAMPLE_LEN +: SAMPLE_LEN];
        end
    endgenerate

`ifdef PACKER_CHANGE_ONLY_EN
    logic [SAMPLE_LEN-1:0] last_reg;
    logic                  first_reg;

    assign changed = first_reg || (sample_i != last_reg);

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            last_reg  <= '0;
            first_reg <= 1'b0;
        end else if (start) begin
            first_reg <= 1'b1;
        end else if (accept) begin
            last_reg  <= sample_i;
            first_reg <= 1'b0;
        end
    end
`else
    assign changed = 1'b1;
`endif

    assign wen_o      = pending_reg & ~full_i;
    assign data_o     = out_reg;
    assign overflow_o = overflow_reg;
    assign busy_o     = (state_reg != IDLE) || pending_reg;

    // The output register is free if empty or being drained this very cycle.
    assign free       = !pending_reg || wen_o;
    assign start      = (state_reg == IDLE) && en_i;
    assign accept     = (state_reg == PACK) && en_i && sample_valid_i && changed;
    assign complete   = accept && (slot_reg == LAST_SLOT);
    assign flush_load = (state_reg == FLUSH) && free;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en_i) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                if (!en_i) begin
                    state_next = (slot_reg != '0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg     <= '0;
            acc_reg      <= '0;
            out_reg      <= '0;
            pending_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (wen_o) begin
                pending_reg <= 1'b0;
            end
            if (start) begin
                slot_reg     <= '0;
                acc_reg      <= '0;
                overflow_reg <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    slot_reg <= '0;
                    acc_reg  <= '0;
                    if (free) begin
                        out_reg     <= word_ins;
                        pending_reg <= 1'b1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end else begin
                    slot_reg <= slot_reg + SLOT_W'(1);
                    acc_reg  <= word_ins;
                end
            end
            // Unused upper slots of a partial word are already zero in the accumulator.
            if (flush_load) begin
                out_reg     <= acc_reg;
                pending_reg <= 1'b1;
                slot_reg    <= '0;
                acc_reg     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: cycle table for packing/throughput, hand-written corner
// sequences, and a write scoreboard fed with the expected words as stimulus is driven.
module tb_sample_packer;

    logic        clk_wr = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        sample_valid_i = 1'b0;
    logic [7:0]  sample_i = 8'h00;
    logic        full_i = 1'b0;
    logic [31:0] data_o;
    logic        wen_o;
    logic        overflow_o;
    logic        busy_o;

    int compared = 0;
    int mismatched = 0;
    int writes = 0;
    logic [31:0] exp_q[$];

    sample_packer #(.DATA_LEN(32), .SAMPLE_LEN(8)) dut (
        .clk_wr(clk_wr),
        .rst_n(rst_n),
        .en_i(en_i),
        .sample_valid_i(sample_valid_i),
        .sample_i(sample_i),
        .full_i(full_i),
        .data_o(data_o),
        .wen_o(wen_o),
        .overflow_o(overflow_o),
        .busy_o(busy_o)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic        en;
        logic        valid;
        logic [7:0]  sample;
        logic        full;
        logic        exp_wen;
        logic [31:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, return at mid-cycle for sampling.
    task automatic cyc(input logic en, input logic valid, input logic [7:0] s, input logic full);
        @(posedge clk_wr);
        #1;
        en_i = en;
        sample_valid_i = valid;
        sample_i = s;
        full_i = full;
        @(negedge clk_wr);
    endtask

    // Scoreboard: every FIFO write must match the oldest expected word.
    always @(negedge clk_wr) begin
        if (rst_n === 1'b1 && wen_o === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got 0x%08h expected no write", data_o);
            end else begin
                logic [31:0] exp;
                exp = exp_q.pop_front();
                $display("write %0d data=0x%08h expected=0x%08h", writes, data_o, exp);
                check("write_data", data_o, exp);
            end
        end
    end

    initial begin
        // Each row: inputs held for one cycle and the outputs expected during that same cycle.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h44332211, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h44332211, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h44332211, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h44332211, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32'h44332211, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 32'h44332211, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 32'h44332211, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 32'h44332211, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 32'h04030201, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 32'h04030201, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 32'h04030201, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 32'h04030201, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h08070605, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h08070605, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h08070605, 1'b0};

        // Reset state
        repeat (2) @(negedge clk_wr);
        check("reset_data", data_o, 32'h0);
        check("reset_wen", {31'b0, wen_o}, 32'h0);
        check("reset_ovf", {31'b0, overflow_o}, 32'h0);
        check("reset_busy", {31'b0, busy_o}, 32'h0);
        rst_n = 1'b1;

        // Packing and sustained throughput
        exp_q.push_back(32'h44332211);
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].en, vecs[i].valid, vecs[i].sample, vecs[i].full);
            check($sformatf("vec%0d_wen", i), {31'b0, wen_o}, {31'b0, vecs[i].exp_wen});
            check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, vecs[i].exp_busy});
        end

        // Flush of a partial word
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h00000605);
        cyc(1, 0, 8'h00, 0);
        for (int k = 1; k <= 6; k++) cyc(1, 1, 8'(k), 0);
        cyc(0, 0, 8'h00, 0);
        check("flush_busy_pack", {31'b0, busy_o}, 32'h1);
        cyc(0, 0, 8'h00, 0);
        check("flush_busy_flush", {31'b0, busy_o}, 32'h1);
        cyc(0, 0, 8'h00, 0);
        check("flush_wen", {31'b0, wen_o}, 32'h1);
        check("flush_busy_write", {31'b0, busy_o}, 32'h1);
        cyc(0, 0, 8'h00, 0);
        check("flush_busy_done", {31'b0, busy_o}, 32'h0);

        // Backpressure: full held for 10 cycles
        exp_q.push_back(32'hA4A3A2A1);
        cyc(1, 0, 8'h00, 1);
        for (int k = 1; k <= 4; k++) cyc(1, 1, 8'hA0 + 8'(k), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 8'h00, 1);
            check($sformatf("bp_wen%0d", k), {31'b0, wen_o}, 32'h0);
            check($sformatf("bp_data%0d", k), data_o, 32'hA4A3A2A1);
        end
        cyc(1, 0, 8'h00, 0);
        check("bp_release_wen", {31'b0, wen_o}, 32'h1);
        cyc(0, 0, 8'h00, 0);
        check("bp_after_wen", {31'b0, wen_o}, 32'h0);
        cyc(0, 0, 8'h00, 0);

        // Overflow: second completed word dropped while full
        exp_q.push_back(32'hB4B3B2B1);
        cyc(1, 0, 8'h00, 1);
        for (int k = 1; k <= 8; k++) cyc(1, 1, 8'hB0 + 8'(k), 1);
        cyc(1, 0, 8'h00, 1);
        check("ovf_set", {31'b0, overflow_o}, 32'h1);
        check("ovf_held_data", data_o, 32'hB4B3B2B1);
        cyc(1, 0, 8'h00, 0);
        check("ovf_drain_wen", {31'b0, wen_o}, 32'h1);
        cyc(1, 0, 8'h00, 0);
        check("ovf_no_second", {31'b0, wen_o}, 32'h0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        check("ovf_sticky_idle", {31'b0, overflow_o}, 32'h1);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        check("ovf_cleared", {31'b0, overflow_o}, 32'h0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        // Completion in the same cycle as a drain reloads without dropping
        exp_q.push_back(32'hC4C3C2C1);
        exp_q.push_back(32'hC8C7C6C5);
        cyc(1, 0, 8'h00, 1);
        for (int k = 1; k <= 7; k++) cyc(1, 1, 8'hC0 + 8'(k), 1);
        cyc(1, 1, 8'hC8, 0);
        check("sim_drain_wen", {31'b0, wen_o}, 32'h1);
        cyc(1, 0, 8'h00, 0);
        check("sim_reload_wen", {31'b0, wen_o}, 32'h1);
        check("sim_no_ovf", {31'b0, overflow_o}, 32'h0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        // en falling together with a valid sample: sample not taken
        exp_q.push_back(32'h0000D2D1);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 1, 8'hD1, 0);
        cyc(1, 1, 8'hD2, 0);
        cyc(0, 1, 8'hD3, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        check("enfall_data", data_o, 32'h0000D2D1);
        cyc(0, 0, 8'h00, 0);

        // FLUSH blocked by full, en re-asserted during FLUSH is ignored
        exp_q.push_back(32'hE4E3E2E1);
        exp_q.push_back(32'h000000E5);
        exp_q.push_back(32'hF4F3F2F1);
        cyc(1, 0, 8'h00, 1);
        for (int k = 1; k <= 5; k++) cyc(1, 1, 8'hE0 + 8'(k), 1);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 8'h99, 1);
            check($sformatf("fwait_busy%0d", k), {31'b0, busy_o}, 32'h1);
            check($sformatf("fwait_wen%0d", k), {31'b0, wen_o}, 32'h0);
        end
        cyc(1, 1, 8'h99, 0);
        check("fwait_drain", data_o, 32'hE4E3E2E1);
        cyc(1, 1, 8'h99, 0);
        check("fwait_partial", data_o, 32'h000000E5);
        for (int k = 1; k <= 4; k++) cyc(1, 1, 8'hF0 + 8'(k), 0);
        cyc(1, 0, 8'h00, 0);
        check("fwait_next_word", data_o, 32'hF4F3F2F1);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        // Asynchronous reset with a pending word and a partial word in flight
        cyc(1, 0, 8'h00, 1);
        for (int k = 1; k <= 4; k++) cyc(1, 1, 8'h60 + 8'(k), 1);
        for (int k = 1; k <= 3; k++) cyc(1, 1, 8'h50 + 8'(k), 1);
        #2;
        rst_n = 1'b0;
        full_i = 1'b0;
        en_i = 1'b0;
        sample_valid_i = 1'b0;
        #1;
        check("rst_wen", {31'b0, wen_o}, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_ovf", {31'b0, overflow_o}, 32'h0);
        @(negedge clk_wr);
        rst_n = 1'b1;
        exp_q.push_back(32'h5D5C5B5A);
        cyc(1, 0, 8'h00, 0);
        for (int k = 0; k < 4; k++) cyc(1, 1, 8'h5A + 8'(k), 0);
        cyc(1, 0, 8'h00, 0);
        check("rst_clean_wen", {31'b0, wen_o}, 32'h1);
        check("rst_clean_data", data_o, 32'h5D5C5B5A);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

`ifdef PACKER_CHANGE_ONLY_EN
        // Repeated samples are skipped
        exp_q.push_back(32'hDDCCBBAA);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 1, 8'hAA, 0);
        cyc(1, 1, 8'hAA, 0);
        cyc(1, 1, 8'hBB, 0);
        cyc(1, 1, 8'hBB, 0);
        cyc(1, 1, 8'hCC, 0);
        cyc(1, 1, 8'hDD, 0);
        cyc(1, 0, 8'h00, 0);
        check("chg_wen", {31'b0, wen_o}, 32'h1);
        check("chg_data", data_o, 32'hDDCCBBAA);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
`endif

        repeat (3) cyc(0, 0, 8'h00, 0);
        check("scoreboard_left", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
# sample_packer

Packs narrow logic-analyzer probe samples into full-width words and writes them into the write port of the dual-clock capture FIFO. It runs entirely in the write-clock domain. It converts a per-cycle sample stream into one FIFO write per `DATA_LEN/SAMPLE_LEN` samples, respects FIFO backpressure through its `full` flag, and flushes partial words when capture stops.

## Interface
- `DATA_LEN`, 32: width of the packed word; equals the FIFO data width.
- `SAMPLE_LEN`, 8: probe channel count. Must divide `DATA_LEN` evenly; `SPW = DATA_LEN/SAMPLE_LEN` (slots per word, 4 by default).
- `clk_wr`  in  1  write-domain clock, shared with the FIFO write side.
- `rst_n`  in  1  asynchronous active-low reset.
- `en_i`  in  1  capture enable; level-sensitive.
- `sample_valid_i`  in  1  `sample_i` is valid this cycle.
- `sample_i`  in  `SAMPLE_LEN`  probe sample.
- `full_i`  in  1  FIFO full flag; combinational from the FIFO, same domain.
- `data_o`  out  `DATA_LEN`  packed word to the FIFO `data_i`.
- `wen_o`  out  1  FIFO write strobe (to `wen_i`).
- `overflow_o`  out  1  sticky: at least one completed word was dropped.
- `busy_o`  out  1  high when the FSM is not IDLE or a word is pending.

## Operation
- FSM states:
  - IDLE -> PACK on `en_i`=1. This transition clears `overflow_o` and `slot`.
  - PACK -> FLUSH on `en_i`=0 when `slot`≠0.
  - PACK -> IDLE on `en_i`=0 when `slot`=0.
  - FLUSH -> IDLE once the partial word is loaded into the output register.
- Accept condition: `state==PACK && en_i && sample_valid_i`. Samples in IDLE or FLUSH are ignored.
- Slot packing:
  - An accepted sample is written to accumulator bits `[slot*SAMPLE_LEN +: SAMPLE_LEN]`, LSB-first.
  - `slot` is a `$clog2(SPW)`-bit counter that increments on accept and wraps SPW-1 -> 0.
- Output stage: register `out_q` plus a `pending` flag.
  - `wen_o = pending & ~full_i` (combinational).
  - `data_o = out_q`.
  - `pending` clears on any cycle where `wen_o`=1, unless it is reloaded in that same cycle.
- Word completion: an accept with `slot==SPW-1`.
  - If `!pending`, or `wen_o`=1 this cycle, then `out_q` <= completed word and `pending`<=1.
  - Otherwise the word is dropped and `overflow_o`<=1.
  - In both cases the accumulator restarts at slot 0.
- Flush:
  - In FLUSH, the partial word is loaded into `out_q` with unused upper slots forced to 0, under the same free condition as above.
  - If the output stage is not free, FLUSH waits. Flush never drops data.
  - The accumulator and `slot` clear on load.
- Full boundary: while `full_i`=1, `pending` holds and `data_o` is stable. At most one completed word is buffered; the next completion drops.

## Timing
- Reset values:
  - `data_o`=0, `wen_o`=0, `overflow_o`=0, `busy_o`=0.
  - Internally: state IDLE, `slot`=0, accumulator=0, `pending`=0.
- Latency: when the SPW-th sample is accepted at edge N, `wen_o` is high in the cycle after edge N, provided `full_i`=0.
- Throughput: one sample per cycle is sustained indefinitely while `full_i`=0. This gives at most one write every SPW cycles.
- Simultaneous events:
  - `en_i` falling in the same cycle as `sample_valid_i`: the sample is not accepted.
  - Completion in the same cycle as a `wen_o` drain: reload with no drop.
- `en_i` re-asserted during FLUSH: it is ignored until IDLE is reached. It takes effect (IDLE->PACK) on the next edge after IDLE.
- Reset asserted mid-operation: all state clears immediately. An in-progress or pending word is lost and `wen_o` drops asynchronously.

## Configuration
- `PACKER_CHANGE_ONLY_EN` defined:
  - A sample is accepted only if it differs from the last accepted sample.
  - The first sample after IDLE->PACK is always accepted.
  - The last-sample register resets to 0.
- `PACKER_CHANGE_ONLY_EN` undefined: every valid sample is accepted; the last-sample register is not instantiated.

## Test plan
- Packing: `en_i`=1, `full_i`=0, valid samples 0x11,0x22,0x33,0x44 on consecutive cycles -> one `wen_o` pulse, one cycle after the 4th sample, with `data_o`=0x44332211.
- Flush: 6 samples 0x01..0x06, then `en_i`=0 -> writes 0x04030201 then 0x00000605; `busy_o` falls after the second write.
- Backpressure: `full_i`=1 held for 10 cycles while 4 samples complete a word -> `wen_o`=0 and `data_o` stable throughout; `wen_o`=1 in the first cycle `full_i`=0.
- Overflow: `full_i`=1, 8 continuous samples -> first word held, second dropped, `overflow_o`=1. After `full_i`=0 only the first word is written. `overflow_o` clears on the next IDLE->PACK.
- Reset mid-word: 3 samples, then `rst_n` pulsed low -> all outputs 0, no write. The next 4 samples produce a clean word.
- With `PACKER_CHANGE_ONLY_EN` defined: samples 0xAA,0xAA,0xBB,0xBB,0xCC,0xDD -> one write 0xDDCCBBAA.
